tunnel_frame_writer: RTL and testbench



---
 rtl/tunnel_frame_writer_pkg.sv | 31 +++
 rtl/tunnel_frame_writer_classifier.sv | 61 ++++++
 rtl/tunnel_frame_writer.sv | 111 +++++++++++
 tb/tb_tunnel_frame_writer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tunnel_frame_writer_pkg.sv
// Shared types and constants for the tunnel back-buffer writer.
// RING_OBSTACLE_EN (optional) enables the red obstacle overlay.
package tunnel_frame_writer_pkg;

  localparam int BUF_COLS = 128;
  localparam int BUF_ROWS = 64;
  localparam int ADDR_W   = 13;

  localparam logic [1:0] PIX_EMPTY = 2'b00;
  localparam logic [1:0] PIX_CORE  = 2'b01;
  localparam logic [1:0] PIX_RING  = 2'b10;
  localparam logic [1:0] PIX_OBS   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic [6:0] cc;
    logic [5:0] cr;
    logic [3:0] phase;
    logic       ov;
    logic [6:0] oc;
    logic [5:0] orow;
    logic [4:0] ow;
    logic [4:0] oh;
  } geom_t;

endpackage

// File: rtl/tunnel_frame_writer_classifier.sv
// Combinational per-cell pixel classifier (stage 1 of the writer).
// RING_OBSTACLE_EN compiles in the obstacle overlay.
module tunnel_cell_classifier
  import tunnel_frame_writer_pkg::*;
#(
  parameter int NUM_RINGS = 4,
  parameter int RING_BASE = 3,
  parameter int RING_STEP = 6
) (
  input  logic [6:0] i_col,
  input  logic [5:0] i_row,
  input  geom_t      i_geom,
  output logic [1:0] o_code
);

  logic [7:0] w_dc;
  logic [7:0] w_dr;
  logic [7:0] w_d;
  logic       w_ring;
  logic       w_core;
  logic       w_obs;

  always_comb begin
    w_dc = (i_col >= i_geom.cc) ? {1'b0, i_col - i_geom.cc}
                                : {1'b0, i_geom.cc - i_col};
    w_dr = (i_row >= i_geom.cr) ? {2'b0, i_row - i_geom.cr}
                                : {2'b0, i_geom.cr - i_row};
    // Columns count double so the rings look square on screen
    w_d = ({w_dc[6:0], 1'b0} > w_dr) ? {w_dc[6:0], 1'b0} : w_dr;
    w_ring = 1'b0;
    for (int k = 0; k < NUM_RINGS; k++) begin
      if ({2'b0, w_d} == 10'(RING_BASE + k * RING_STEP)
                         + {6'b0, i_geom.phase})
        w_ring = 1'b1;
    end
    w_core = {2'b0, w_d} < 10'(RING_BASE) + {6'b0, i_geom.phase};
  end

`ifdef RING_OBSTACLE_EN
  always_comb begin
    w_obs = i_geom.ov
         && ({1'b0, i_col} >= {1'b0, i_geom.oc})
         && ({1'b0, i_col} < {1'b0, i_geom.oc} + {3'b0, i_geom.ow})
         && ({2'b0, i_row} >= {2'b0, i_geom.orow})
         && ({2'b0, i_row} < {2'b0, i_geom.orow} + {3'b0, i_geom.oh});
  end
`else
  logic w_unused;
  assign w_unused = ^{i_geom.ov, i_geom.oc, i_geom.orow,
                      i_geom.ow, i_geom.oh};
  assign w_obs = 1'b0;
`endif

  always_comb begin
    if (w_obs)       o_code = PIX_OBS;
    else if (w_ring) o_code = PIX_RING;
    else if (w_core) o_code = PIX_CORE;
    else             o_code = PIX_EMPTY;
  end

endmodule

// File: rtl/tunnel_frame_writer.sv
// Rasters the 128x64 tunnel back buffer onto the BRAM write bus.
// RING_OBSTACLE_EN enables obstacle code 11 in the classifier.
module tunnel_frame_writer
  import tunnel_frame_writer_pkg::*;
#(
  parameter int NUM_RINGS = 4,
  parameter int RING_BASE = 3,
  parameter int RING_STEP = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        topready,
  input  logic [6:0]  center_col,
  input  logic [5:0]  center_row,
  input  logic [3:0]  ring_phase,
  input  logic        obs_valid,
  input  logic [6:0]  obs_col,
  input  logic [5:0]  obs_row,
  input  logic [4:0]  obs_w,
  input  logic [4:0]  obs_h,
  output logic [14:0] bramdata,
  output logic        ewrite,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  geom_t               r_geom;
  logic                r_drain;
  logic                r_s1_valid;
  logic [ADDR_W-1:0]   r_s1_addr;
  logic [1:0]          r_s1_code;
  logic [1:0]          w_code;

  tunnel_cell_classifier #(
    .NUM_RINGS (NUM_RINGS),
    .RING_BASE (RING_BASE),
    .RING_STEP (RING_STEP)
  ) u_cls (
    .i_col  (r_cnt[12:6]),
    .i_row  (r_cnt[5:0]),
    .i_geom (r_geom),
    .o_code (w_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_geom     <= '0;
      r_drain    <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_code  <= PIX_EMPTY;
      bramdata   <= '0;
      ewrite     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      r_s1_valid <= (r_state == ST_SCAN);
      r_s1_addr  <= r_cnt;
      r_s1_code  <= w_code;
      ewrite     <= r_s1_valid;
      if (r_s1_valid)
        bramdata <= {r_s1_addr, r_s1_code};
      unique case (r_state)
        ST_IDLE: begin
          if (topready) begin
            r_geom.cc    <= center_col;
            r_geom.cr    <= center_row;
            r_geom.phase <= 4'(ring_phase % 4'(RING_STEP));
            r_geom.ov    <= obs_valid;
            r_geom.oc    <= obs_col;
            r_geom.orow  <= obs_row;
            r_geom.ow    <= obs_w;
            r_geom.oh    <= obs_h;
            r_cnt        <= '0;
            busy         <= 1'b1;
            r_state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          overrun <= topready;
          if (&r_cnt) begin
            r_drain <= 1'b0;
            r_state <= ST_DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          overrun <= topready;
          if (r_drain) begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_drain <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tunnel_frame_writer.sv
// Directed bench for tunnel_frame_writer: full passes checked
// against hand-computed cell codes plus overrun/reset corners.
module tb_tunnel_frame_writer;

`ifdef RING_OBSTACLE_EN
  localparam bit OBS_EN = 1'b1;
`else
  localparam bit OBS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        topready;
  logic [6:0]  center_col;
  logic [5:0]  center_row;
  logic [3:0]  ring_phase;
  logic        obs_valid;
  logic [6:0]  obs_col;
  logic [5:0]  obs_row;
  logic [4:0]  obs_w;
  logic [4:0]  obs_h;
  logic [14:0] bramdata;
  logic        ewrite;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  tunnel_frame_writer dut (
    .clk        (clk),
    .rst        (rst),
    .topready   (topready),
    .center_col (center_col),
    .center_row (center_row),
    .ring_phase (ring_phase),
    .obs_valid  (obs_valid),
    .obs_col    (obs_col),
    .obs_row    (obs_row),
    .obs_w      (obs_w),
    .obs_h      (obs_h),
    .bramdata   (bramdata),
    .ewrite     (ewrite),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] mem [0:8191];
  int nwr, first_cyc, fd_cyc, fd_cnt, ov_cnt, last_addr, t0;
  bit gap;
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    if (ewrite === 1'b1) begin
      if (nwr == 0) first_cyc = cyc;
      else if (int'(bramdata[14:2]) != last_addr + 1) gap = 1'b1;
      last_addr = int'(bramdata[14:2]);
      mem[bramdata[14:2]] = bramdata[1:0];
      nwr++;
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (overrun === 1'b1) ov_cnt++;
  end

  typedef struct {
    int         pid;
    int         col;
    int         row;
    logic [1:0] on;
    logic [1:0] off;
  } vec_t;
  vec_t tbl[$];

  task automatic add(int p, int c, int r, logic [1:0] on,
                     logic [1:0] off);
    vec_t v;
    v.pid = p; v.col = c; v.row = r; v.on = on; v.off = off;
    tbl.push_back(v);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start(int cc, int cr, int ph, bit ov, int oc,
                       int orr, int ow, int oh);
    center_col = 7'(cc);
    center_row = 6'(cr);
    ring_phase = 4'(ph);
    obs_valid  = ov;
    obs_col    = 7'(oc);
    obs_row    = 6'(orr);
    obs_w      = 5'(ow);
    obs_h      = 5'(oh);
    topready   = 1'b1;
    t0 = cyc;
    nwr = 0; gap = 1'b0; fd_cnt = 0; ov_cnt = 0;
    first_cyc = -1; fd_cyc = -1;
    for (int i = 0; i < 8192; i++) mem[i] = 2'bxx;
    step();
    topready = 1'b0;
  endtask

  task automatic finish_pass(string nm);
    for (int i = 0; i < 9000 && fd_cnt == 0; i++) step();
    chk({nm, "_done"}, fd_cnt, 1);
    chk({nm, "_first"}, first_cyc - t0, 3);
    chk({nm, "_fdlat"}, fd_cyc - t0, 8195);
    chk({nm, "_nwr"}, nwr, 8192);
    chk({nm, "_gap"}, gap, 0);
    chk({nm, "_busy0"}, busy, 0);
  endtask

  task automatic check_table(int pid);
    foreach (tbl[i]) begin
      if (tbl[i].pid == pid)
        chk($sformatf("cell_p%0d_c%0d_r%0d", pid, tbl[i].col,
                      tbl[i].row),
            mem[tbl[i].col * 64 + tbl[i].row],
            OBS_EN ? tbl[i].on : tbl[i].off);
    end
  endtask

  initial begin
    // Centre (64,32), phase 0: rings at 3,9,15,21, core d<3
    add(0, 64, 32, 2'b01, 2'b01);
    add(0, 64, 35, 2'b10, 2'b10);
    add(0, 64, 41, 2'b10, 2'b10);
    add(0, 64, 38, 2'b00, 2'b00);
    add(0, 65, 32, 2'b01, 2'b01);
    add(0, 66, 32, 2'b00, 2'b00);
    add(0,  0,  0, 2'b00, 2'b00);
    add(0, 64, 53, 2'b10, 2'b10);
    add(0, 64, 59, 2'b00, 2'b00);
    add(0, 63, 31, 2'b01, 2'b01);
    // Phase 2: rings at 5,11,17,23, core d<5
    add(1, 64, 37, 2'b10, 2'b10);
    add(1, 64, 35, 2'b01, 2'b01);
    add(1, 64, 36, 2'b01, 2'b01);
    add(1, 64, 43, 2'b10, 2'b10);
    add(1, 66, 32, 2'b01, 2'b01);
    add(1, 67, 32, 2'b00, 2'b00);
    // Phase 5 with obstacle (60,30) 4x4: rings 8,14,.. core d<8
    add(3, 60, 30, 2'b11, 2'b10);
    add(3, 63, 32, 2'b11, 2'b01);
    add(3, 62, 33, 2'b11, 2'b01);
    add(3, 63, 33, 2'b11, 2'b01);
    add(3, 64, 32, 2'b01, 2'b01);
    add(3, 64, 30, 2'b01, 2'b01);
    add(3, 59, 30, 2'b00, 2'b00);
    add(3, 60, 34, 2'b10, 2'b10);
    add(3, 60, 29, 2'b10, 2'b10);
    // Edge obstacle (126,62) 8x8, phase 0
    add(4, 126, 62, 2'b11, 2'b00);
    add(4, 127, 63, 2'b11, 2'b00);
    add(4, 127, 62, 2'b11, 2'b00);
    add(4, 125, 62, 2'b00, 2'b00);
    add(4, 126, 61, 2'b00, 2'b00);
    add(4,   0,  0, 2'b00, 2'b00);
    add(4,   0, 62, 2'b00, 2'b00);
    add(4, 126,  0, 2'b00, 2'b00);
    add(4,   1,  1, 2'b00, 2'b00);

    rst = 1'b1; topready = 1'b0;
    center_col = '0; center_row = '0; ring_phase = '0;
    obs_valid = 1'b0; obs_col = '0; obs_row = '0;
    obs_w = '0; obs_h = '0;
    nwr = 0; fd_cnt = 0; ov_cnt = 0; gap = 1'b0;
    repeat (3) step();
    chk("rst_bramdata", bramdata, 0);
    chk("rst_ewrite", ewrite, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    step();

    start(64, 32, 0, 0, 0, 0, 0, 0);
    chk("p0_busy1", busy, 1);
    finish_pass("p0");
    check_table(0);

    step(); start(64, 32, 2, 0, 0, 0, 0, 0);
    finish_pass("p1"); check_table(1);

    step(); start(64, 32, 8, 0, 0, 0, 0, 0);
    finish_pass("p8"); check_table(1);

    step(); start(64, 32, 5, 1, 60, 30, 4, 4);
    finish_pass("obs"); check_table(3);

    step(); start(64, 32, 0, 1, 126, 62, 8, 8);
    finish_pass("edge"); check_table(4);

    // Second topready mid-pass must only raise overrun
    step(); start(64, 32, 0, 0, 0, 0, 0, 0);
    while (cyc < t0 + 100) step();
    topready = 1'b1;
    step();
    topready = 1'b0;
    finish_pass("ovr");
    chk("ovr_pulses", ov_cnt, 1);
    chk("coinc_fd", frame_done, 1);

    // topready in the frame_done cycle starts a new pass
    start(64, 32, 0, 0, 0, 0, 0, 0);
    finish_pass("coinc");
    chk("coinc_ovr", ov_cnt, 0);
    check_table(0);

    // Reset mid-pass
    step(); start(64, 32, 0, 0, 0, 0, 0, 0);
    while (cyc < t0 + 4000) step();
    chk("mid_ewrite1", ewrite, 1);
    rst = 1'b1;
    #1;
    chk("mid_ewrite0", ewrite, 0);
    chk("mid_busy0", busy, 0);
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();
    chk("mid_no_fd", fd_cnt, 0);
    start(64, 32, 0, 0, 0, 0, 0, 0);
    finish_pass("post_rst");
    check_table(0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
